// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem request, redirect and flush.
// Define FETCH_ADEL_EN to enable fetch address-error (AdEL) checking.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        BrJumpD,
    input  logic        BrTakenD,
    input  logic [31:0] BrTargetD,
    input  logic        ExcReq,
    input  logic        EretReq,
    input  logic [31:0] EPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] InstF,
    output logic [31:0] PCF,
    output logic [31:0] PC4F,
    output logic        ExcBDF,
    output logic [4:0]  ExcCodeF,
    output logic        ValidF,
    output logic        FetchStallF
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [4:0]  EC_ADEL  = 5'd4;

    typedef enum logic {
        FETCH,
        HAVE
    } state_t;

    state_t      state = FETCH;
    state_t      state_n;
    logic [31:0] pc = RESET_PC;
    logic [31:0] pc_n;
    logic [31:0] inst = '0;
    logic [31:0] inst_n;
    logic        valid = 1'b0;
    logic        valid_n;
    logic [4:0]  exc = '0;
    logic [4:0]  exc_n;
    logic        pend = 1'b0;
    logic        pend_n;
    logic [31:0] ptgt = '0;
    logic [31:0] ptgt_n;

    logic        flush;
    logic [31:0] ftgt;
    logic        fault;

    assign flush = ExcReq | EretReq;
    assign ftgt  = ExcReq ? EXC_VEC : EPC;

`ifdef FETCH_ADEL_EN
    localparam logic [31:0] TEXT_LO = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI = 32'h0000_6FFC;
    assign fault = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        inst_n    = inst;
        valid_n   = valid;
        exc_n     = exc;
        pend_n    = pend;
        ptgt_n    = ptgt;
        imem_req  = 1'b0;
        imem_addr = pc;
        unique case (state)
            FETCH: begin
                if (fault) begin
                    // no bus access for a bad address; deliver the fault instead
                    if (flush) begin
                        pc_n = ftgt;
                    end else begin
                        inst_n  = '0;
                        exc_n   = EC_ADEL;
                        valid_n = 1'b1;
                        state_n = HAVE;
                    end
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        if (flush) begin
                            pc_n   = ftgt;
                            pend_n = 1'b0;
                        end else if (pend) begin
                            pc_n   = ptgt;
                            pend_n = 1'b0;
                        end else begin
                            inst_n  = imem_rdata;
                            exc_n   = '0;
                            valid_n = 1'b1;
                            state_n = HAVE;
                        end
                    end else if (flush) begin
                        // request still in flight: remember where to go
                        pend_n = 1'b1;
                        ptgt_n = ftgt;
                    end
                end
            end
            HAVE: begin
                if (flush) begin
                    pc_n    = ftgt;
                    valid_n = 1'b0;
                    exc_n   = '0;
                    state_n = FETCH;
                end else if (!en) begin
                    pc_n    = BrTakenD ? BrTargetD : pc + 32'd4;
                    valid_n = 1'b0;
                    exc_n   = '0;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            inst  <= '0;
            valid <= 1'b0;
            exc   <= '0;
            pend  <= 1'b0;
            ptgt  <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            inst  <= inst_n;
            valid <= valid_n;
            exc   <= exc_n;
            pend  <= pend_n;
            ptgt  <= ptgt_n;
        end
    end

    assign InstF       = inst;
    assign PCF         = pc;
    assign PC4F        = pc + 32'd4;
    assign ExcBDF      = valid & BrJumpD;
    assign ExcCodeF    = exc;
    assign ValidF      = valid;
    assign FetchStallF = ~valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random redirects, flushes, stalls, latencies.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        BrJumpD = 1'b0;
    logic        BrTakenD = 1'b0;
    logic [31:0] BrTargetD = '0;
    logic        ExcReq = 1'b0;
    logic        EretReq = 1'b0;
    logic [31:0] EPC = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] InstF;
    logic [31:0] PCF;
    logic [31:0] PC4F;
    logic        ExcBDF;
    logic [4:0]  ExcCodeF;
    logic        ValidF;
    logic        FetchStallF;

    fetch_unit dut (
        .clk(clk), .reset(reset), .en(en),
        .BrJumpD(BrJumpD), .BrTakenD(BrTakenD), .BrTargetD(BrTargetD),
        .ExcReq(ExcReq), .EretReq(EretReq), .EPC(EPC),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .InstF(InstF), .PCF(PCF), .PC4F(PC4F), .ExcBDF(ExcBDF),
        .ExcCodeF(ExcCodeF), .ValidF(ValidF), .FetchStallF(FetchStallF)
    );

    always #5 clk = ~clk;

`ifdef FETCH_ADEL_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  exc;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_cur;
    exp_t        got;
    int          checks = 0;
    int          fails = 0;
    logic [31:0] m_pc;
    bit          m_have;
    bit          m_pend;
    logic [31:0] m_ptgt;
    int          m_lat;
    int          force_lat = -1;
    bit          prev_v = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic bit faulty(logic [31:0] p);
        return ADEL && ((p[1:0] != 2'b00) || (p < 32'h3000) || (p > 32'h6FFC));
    endfunction

    function automatic exp_t mk(logic [31:0] p);
        exp_t e;
        e.pc = p;
        if (faulty(p)) begin
            e.inst = '0;
            e.exc  = 5'd4;
        end else begin
            e.inst = memf(p);
            e.exc  = 5'd0;
        end
        return e;
    endfunction

    function automatic int newlat();
        if (force_lat >= 0) return force_lat;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic model_init();
        m_pc   = 32'h3000;
        m_have = 1'b0;
        m_pend = 1'b0;
        sb.delete();
        sb.push_back(mk(32'h3000));
        m_lat  = newlat();
    endtask

    task automatic redirect(logic [31:0] t);
        m_pc   = t;
        m_have = 1'b0;
        sb.push_back(mk(t));
        m_lat  = newlat();
    endtask

    task automatic retarget(logic [31:0] t);
        m_pc   = t;
        m_pend = 1'b0;
        void'(sb.pop_back());
        sb.push_back(mk(t));
        m_lat  = newlat();
    endtask

    task automatic deliver();
        m_have = 1'b1;
        m_cur  = sb[0];
    endtask

    task automatic cycle(bit e, bit bj, bit bt, logic [31:0] btgt,
                         bit ex, bit er, logic [31:0] epc);
        bit          fetching;
        bit          flush;
        logic [31:0] tgt;
        @(negedge clk);
        fetching = !m_have && !faulty(m_pc);
        chk1("ValidF", ValidF, m_have);
        chk1("FetchStallF", FetchStallF, !m_have);
        chk1("imem_req", imem_req, fetching);
        if (fetching) chk("imem_addr", imem_addr, m_pc);
        if (m_have) begin
            chk("PCF_hold", PCF, m_pc);
            chk("PC4F_hold", PC4F, m_pc + 32'd4);
            chk("InstF_hold", InstF, m_cur.inst);
            chk("ExcCodeF_hold", 32'(ExcCodeF), 32'(m_cur.exc));
        end
        en = e; BrJumpD = bj; BrTakenD = bt; BrTargetD = btgt;
        ExcReq = ex; EretReq = er; EPC = epc;
        if (fetching && m_lat == 0) begin
            imem_ready = 1'b1;
            imem_rdata = memf(m_pc);
        end else begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            if (fetching) m_lat--;
        end
        #1;
        chk1("ExcBDF", ExcBDF, m_have & bj);
        flush = ex | er;
        tgt   = ex ? 32'h4180 : epc;
        if (m_have) begin
            if (flush) redirect(tgt);
            else if (!e) redirect(bt ? btgt : m_pc + 32'd4);
        end else if (!fetching) begin
            if (flush) retarget(tgt);
            else deliver();
        end else if (imem_ready) begin
            if (flush) retarget(tgt);
            else if (m_pend) retarget(m_ptgt);
            else deliver();
        end else if (flush) begin
            m_pend = 1'b1;
            m_ptgt = tgt;
            void'(sb.pop_back());
            sb.push_back(mk(tgt));
        end
    endtask

    task automatic rand_cycle();
        bit bj;
        cycle_wrap: begin
            bj = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) == 0, bj, bj & 1'($urandom_range(0, 1)),
                  32'h3000 + 32'(4 * $urandom_range(0, 4095)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  32'h3000 + 32'(4 * $urandom_range(0, 4095)));
        end
    endtask

    task automatic to_have();
        for (int i = 0; i < 10; i++)
            if (!m_have) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0; BrJumpD = 1'b0; BrTakenD = 1'b0;
        ExcReq = 1'b0; EretReq = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk1("rst_ValidF", ValidF, 1'b0);
        chk("rst_InstF", InstF, 32'h0);
        chk("rst_PCF", PCF, 32'h3000);
        chk("rst_ExcCodeF", 32'(ExcCodeF), 32'h0);
        chk1("rst_imem_req", imem_req, 1'b1);
        chk("rst_imem_addr", imem_addr, 32'h3000);
        imem_ready = 1'b0;
        reset = 1'b0;
        model_init();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (ValidF && !prev_v) begin
                chk1("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk("PCF", PCF, got.pc);
                    chk("InstF", InstF, got.inst);
                    chk("PC4F", PC4F, got.pc + 32'd4);
                    chk("ExcCodeF", 32'(ExcCodeF), 32'(got.exc));
                end
            end
            prev_v = ValidF;
        end
    end

    initial begin
        force_lat = 0;
        do_reset();
        repeat (8) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 1'b1, 32'h3100, 1'b0, 1'b0, '0);
        force_lat = 3;
        to_have();
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        force_lat = -1;
        to_have();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, i == 2, 32'h3044);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        to_have();
        cycle(1'b0, 1'b1, 1'b1, 32'h3102, 1'b0, 1'b0, '0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        to_have();
        cycle(1'b0, 1'b1, 1'b1, 32'h3200, 1'b0, 1'b0, '0);
        repeat (3000) rand_cycle();
        for (int i = 0; i < 10; i++)
            if (m_have) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        do_reset();
        repeat (300) rand_cycle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have clk  in  1  pipeline clock; all state updates on posedge clk.
REQ-002 SHALL have reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have en  in  1  pipeline freeze from hazard unit; 1 = hold; handoff to IF/ID only when en=0.
REQ-004 SHALL have BrJumpD  in  1  instruction in decode is a branch/jump.
REQ-005 SHALL have BrTakenD  in  1  decode branch/jump redirects.
REQ-006 SHALL have BrTargetD  in  32  redirect target.
REQ-007 SHALL have ExcReq  in  1  one-cycle exception-entry pulse.
REQ-008 SHALL have EretReq  in  1  one-cycle eret pulse.
REQ-009 SHALL have EPC  in  32  eret return address.
REQ-010 SHALL have imem_req/imem_addr  out  1/32  instruction-memory request and word address.
REQ-011 SHALL have imem_rdata/imem_ready  in  32/1  response data and one-cycle completion strobe.
REQ-012 SHALL have InstF, PCF, PC4F  out  32 each  fetched instruction, its PC, PC+4.
REQ-013 SHALL have ExcBDF  out  1  fetched instruction sits in a delay slot.
REQ-014 SHALL have ExcCodeF  out  5  fetch exception code (0 none, 4 AdEL).
REQ-015 SHALL have ValidF/FetchStallF  out  1/1  instruction held valid / fetch-not-ready freeze request (FetchStallF = ~ValidF).

Function
REQ-016 SHALL implement FSM {FETCH, HAVE}; FETCH drives imem_req=1, imem_addr=PC; HAVE drives imem_req=0.
REQ-017 SHALL, in FETCH with imem_ready=1 and no pending flush, capture InstF<=imem_rdata, set ValidF=1, enter HAVE next cycle (min latency 1 cycle after request).
REQ-018 SHALL perform a handoff when state=HAVE and en=0: PC<=next PC, ValidF<=0, enter FETCH; with en=1 all outputs hold.
REQ-019 SHALL select next PC at handoff by priority BrTakenD ? BrTargetD : PC+4 (PC+4 mod 2^32).
REQ-020 SHALL drive ExcBDF = ValidF & BrJumpD combinationally.
REQ-021 SHALL treat flush priority ExcReq > EretReq; target 0x00004180 or EPC respectively; flush ignores en.
REQ-022 SHALL, on flush in HAVE: PC<=target, ValidF<=0, enter FETCH next cycle.
REQ-023 SHALL, on flush in FETCH: latch target in a pending register; if imem_ready same or later cycle, discard rdata (ValidF stays 0), load PC<=target, re-issue.
REQ-024 SHALL let a later flush overwrite an earlier pending flush; flush overrides BrTakenD in the same cycle.
REQ-025 SHALL keep PCF = PC of InstF and PC4F = PCF+4 whenever ValidF=1.
REQ-026 SHALL never issue a second request before the outstanding one completes.

Reset
REQ-027 SHALL on reset set PC=0x00003000, state=FETCH, InstF=0, ValidF=0, ExcCodeF=0, pending cleared; reset overrides all inputs, including mid-request (late imem_ready ignored).
REQ-028 SHALL initialise the same values at time zero for simulation.

Configuration
REQ-029 SHALL compile fetch address checking only when FETCH_ADEL_EN is defined.
REQ-030 SHALL, with FETCH_ADEL_EN, treat PC with PC[1:0]!=0 or outside 0x00003000..0x00006FFC as faulting: no imem request, enter HAVE next cycle with InstF=0, ExcCodeF=4, ValidF=1.
REQ-031 SHALL, without FETCH_ADEL_EN, fetch any PC and hold ExcCodeF=0.

Verification
REQ-032 Reset, imem_ready one cycle after each req, en=0 -> PCF sequence 0x3000, 0x3004, 0x3008, one instruction per 2 cycles.
REQ-033 BrJumpD=1, BrTakenD=1, BrTargetD=0x3100 at handoff of PC 0x3008 -> ExcBDF=1 for 0x3008; next PCF=0x3100.
REQ-034 ExcReq while FETCH awaits, imem_ready 3 cycles later -> response discarded, next imem_addr=0x00004180.
REQ-035 en=1 for 5 cycles in HAVE -> InstF/PCF unchanged, no new request; EretReq with EPC=0x3044 in that window -> next fetch 0x3044.
REQ-036 With FETCH_ADEL_EN, BrTargetD=0x3102 -> no request, ExcCodeF=4, InstF=0; without -> request at 0x3102, ExcCodeF=0.
